// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner.
//   btn_state_t : per-channel debounce FSM state
//   cnt_width() : bit width needed to count 0 .. n-1 (never less than 1)
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchronizer, polarity normalisation, debounce
// FSM with debounce/hold counters, and registered level/pulse outputs.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   pin           : raw asynchronous button pin
//   level         : debounced state, 1 = pressed
//   press         : one-cycle pulse on accepted press
//   release_pulse : one-cycle pulse on accepted release
//   long_press    : one-cycle pulse once per hold reaching LONG_PRESS_CYCLES
// PIN_IDLE is the raw pin value when not pressed; the synchronizer resets to
// it so no press is seen coming out of reset.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES   = 270_000,
  parameter int   LONG_PRESS_CYCLES = 27_000_000,
  parameter logic PIN_IDLE          = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HCNT_PRE  = HW'(LONG_PRESS_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          p;
  btn_state_t    state_q;
  btn_state_t    state_d;
  logic [DW-1:0] dcnt_q;
  logic [DW-1:0] dcnt_d;
  logic [HW-1:0] hcnt_q;
  logic [HW-1:0] hcnt_d;
  logic [HW-1:0] hcnt_inc;
  logic          level_s;
  logic          press_s;
  logic          release_s;
  logic          long_s;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= PIN_IDLE;
      sync2 <= PIN_IDLE;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // p = 1 while pressed, whatever the pin polarity.
  assign p = sync2 ^ PIN_IDLE;

  // Hold counter saturates at LONG_PRESS_CYCLES so it never wraps.
  assign hcnt_inc = (hcnt_q == HCNT_MAX) ? HCNT_MAX : hcnt_q + HW'(1);

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Next-state and next-counter logic.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      IDLE: begin
        hcnt_d = '0;
        if (p) begin
          state_d = PRESS_WAIT;
          dcnt_d  = DW'(1);
        end else begin
          dcnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        hcnt_d = '0;
        if (!p) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = HELD;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      HELD: begin
        hcnt_d = hcnt_inc;
        if (!p) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = DW'(1);
        end else begin
          dcnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          // Bounce back to pressed: hcnt keeps running so long_press cannot re-arm.
          state_d = HELD;
          dcnt_d  = '0;
          hcnt_d  = hcnt_inc;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = IDLE;
          dcnt_d  = '0;
          hcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
          hcnt_d = hcnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        dcnt_d  = '0;
        hcnt_d  = '0;
      end
    endcase
  end

  // Output decode from the transition being taken this cycle.
  always_comb begin
    level_s   = (state_d == HELD) || (state_d == RELEASE_WAIT);
    press_s   = (state_q == PRESS_WAIT) && (state_d == HELD);
    release_s = (state_q == RELEASE_WAIT) && (state_d == IDLE);
    // Only the L-1 -> L step fires; saturation makes it once per hold.
    long_s    = ((state_q == HELD) || (state_q == RELEASE_WAIT)) &&
                (hcnt_q == HCNT_PRE) && (state_d != IDLE);
  end

  // Registered outputs, updated on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      level         <= level_s;
      press         <= press_s;
      release_pulse <= release_s;
      long_press    <= long_s;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw bouncy push-button pins into clean per-button signals.
// Ports:
//   clk           : 27 MHz board clock
//   rst_n         : asynchronous active-low reset
//   buttons       : raw asynchronous button pins
//   level         : debounced state, 1 = pressed
//   press         : one-cycle pulse on accepted press
//   release_pulse : one-cycle pulse on accepted release (the name "release"
//                   is a reserved word in SystemVerilog)
//   long_press    : one-cycle pulse once per hold reaching LONG_PRESS_CYCLES
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES   = 270_000,
  parameter int LONG_PRESS_CYCLES = 27_000_000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_BUTTONS-1:0] level,
  output logic [NUM_BUTTONS-1:0] press,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] long_press
);

  // Raw pin value of a released button; each channel normalises against it.
  localparam logic PIN_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .PIN_IDLE         (PIN_IDLE)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .pin          (buttons[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i])
    );
  end

endmodule
